// File: rtl/wb_stage_gen.sv
// -----------------------------------------------------------------------------
// wb_stage_gen
//
// Writeback stage between the memory stage and the register file.  Entries
// arrive from the memory stage, wait in a DEPTH-entry in-order circular buffer
// and retire one per cycle to a register-file write port that may stall.
//
// Optional build macro:
//   WB_PERF_CNT_EN  - when defined, perf_retired / perf_stall count retired
//                     entries and stall cycles; when undefined both are 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ms_to_ws_valid/bus    incoming entry {pc, be, raddr, wdata}, MSB first
//   ws_allowin            stage accepts an entry this cycle
//   ws_flush              discard every buffered entry
//   rf_ready              register-file write port accepts this cycle
//   ws_to_rf_bus          {we, waddr, wdata} to the register file
//   ws_busy               buffer holds at least one entry
//   ws_fwd_raddr/hit/be/data  bypass lookup for the decode stage
//   debug_wb_*            trace of the retiring entry
//   perf_retired/stall    performance counters
//
// Handshake: an entry moves from the memory stage into this stage on a rising
// edge where ms_to_ws_valid=1, ws_allowin=1 and ws_flush=0.  The memory stage
// must hold its entry stable while ws_allowin=0.  Towards the register file an
// entry retires on an edge where the buffer is non-empty, rf_ready=1 and
// ws_flush=0; rf_ready never depends on anything this stage drives.
// -----------------------------------------------------------------------------
module wb_stage_gen #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ms_to_ws_valid,
    input  logic [PC_W+DATA_W/8+RADDR_W+DATA_W-1:0] ms_to_ws_bus,
    output logic                                   ws_allowin,
    input  logic                                   ws_flush,
    input  logic                                   rf_ready,
    output logic [DATA_W/8+RADDR_W+DATA_W-1:0]     ws_to_rf_bus,
    output logic                                   ws_busy,
    input  logic [RADDR_W-1:0]                     ws_fwd_raddr,
    output logic                                   ws_fwd_hit,
    output logic [DATA_W/8-1:0]                    ws_fwd_be,
    output logic [DATA_W-1:0]                      ws_fwd_data,
    output logic [PC_W-1:0]                        debug_wb_pc,
    output logic [DATA_W/8-1:0]                    debug_wb_rf_we,
    output logic [RADDR_W-1:0]                     debug_wb_rf_waddr,
    output logic [DATA_W-1:0]                      debug_wb_rf_wdata,
    output logic [CNT_W-1:0]                       perf_retired,
    output logic [CNT_W-1:0]                       perf_stall
);

    localparam int BE_W   = DATA_W / 8;
    localparam int BUS_WD = PC_W + BE_W + RADDR_W + DATA_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Buffer storage and control state
    // ------------------------------------------------------------------
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic [BE_W-1:0]    r_be    [DEPTH];
    logic [RADDR_W-1:0] r_raddr [DEPTH];
    logic [DATA_W-1:0]  r_data  [DEPTH];

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CW-1:0]      r_count;
    logic [PC_W-1:0]    r_last_pc;

    // Incoming entry fields
    logic [PC_W-1:0]    w_in_pc;
    logic [BE_W-1:0]    w_in_be;
    logic [RADDR_W-1:0] w_in_raddr;
    logic [DATA_W-1:0]  w_in_data;

    // Head entry fields
    logic [PC_W-1:0]    w_hd_pc;
    logic [BE_W-1:0]    w_hd_be;
    logic [RADDR_W-1:0] w_hd_raddr;
    logic [DATA_W-1:0]  w_hd_data;

    logic               w_busy;
    logic               w_pop;
    logic               w_push;
    logic [BE_W-1:0]    w_we;
    logic [RADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_in_data  = ms_to_ws_bus[DATA_W-1:0];
    assign w_in_raddr = ms_to_ws_bus[DATA_W +: RADDR_W];
    assign w_in_be    = ms_to_ws_bus[DATA_W+RADDR_W +: BE_W];
    assign w_in_pc    = ms_to_ws_bus[BUS_WD-1 -: PC_W];

    assign w_hd_pc    = r_pc[r_head];
    assign w_hd_be    = r_be[r_head];
    assign w_hd_raddr = r_raddr[r_head];
    assign w_hd_data  = r_data[r_head];

    // Pointers wrap explicitly so that DEPTH=3 works as well as powers of 2.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_busy     = (r_count != '0);
    assign w_pop      = w_busy && rf_ready && !ws_flush;
    // A full buffer still accepts when its head leaves in the same cycle.
    assign ws_allowin = (r_count < DEPTH_C) || w_pop;
    assign w_push     = ms_to_ws_valid && ws_allowin && !ws_flush;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_last_pc <= '0;
        end else if (ws_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head    <= ptr_inc(r_head);
                r_last_pc <= w_hd_pc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; every read is qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]    <= w_in_pc;
            r_be[r_tail]    <= w_in_be;
            r_raddr[r_tail] <= w_in_raddr;
            r_data[r_tail]  <= w_in_data;
        end
    end

    // ------------------------------------------------------------------
    // Register-file write
    // ------------------------------------------------------------------
    // Writes to r0 are suppressed, but the entry still retires.
    assign w_we    = (w_pop && (w_hd_raddr != '0)) ? w_hd_be : '0;
    assign w_waddr = w_busy ? w_hd_raddr : '0;
    assign w_wdata = w_busy ? w_hd_data  : '0;

    assign ws_to_rf_bus      = {w_we, w_waddr, w_wdata};
    assign ws_busy           = w_busy;
    assign debug_wb_rf_we    = w_we;
    assign debug_wb_rf_waddr = w_waddr;
    assign debug_wb_rf_wdata = w_wdata;
    assign debug_wb_pc       = w_pop ? w_hd_pc : r_last_pc;

    // ------------------------------------------------------------------
    // Bypass search
    // ------------------------------------------------------------------
    // Walk valid entries from oldest to youngest; a later match overwrites
    // an earlier one so the youngest entry wins.
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        ws_fwd_hit  = 1'b0;
        ws_fwd_be   = '0;
        ws_fwd_data = '0;
        w_idx       = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (ws_fwd_raddr != '0) &&
                (r_raddr[w_idx] == ws_fwd_raddr) && (r_be[w_idx] != '0)) begin
                ws_fwd_hit  = 1'b1;
                ws_fwd_be   = r_be[w_idx];
                ws_fwd_data = r_data[w_idx];
            end
            w_idx = ptr_inc(w_idx);
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_retired;
    logic [CNT_W-1:0] r_perf_stall;

    // Cleared by reset only; a flush leaves both counts untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop) begin
                r_perf_retired <= r_perf_retired + 1'b1;
            end
            if (w_busy && !rf_ready && !ws_flush) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: doc/wb_stage_gen.md
Name: wb_stage_gen

Overview:
Parametrised writeback stage that sits between the memory stage and the register file.
- Accepts ms_to_ws_bus entries through the valid/allowin handshake into a DEPTH-entry in-order buffer.
- Retires one entry per cycle to a register-file write port that can apply backpressure (rf_ready).
- Provides byte-lane write enables, a bypass lookup port for the decode stage, flush support and debug trace outputs.

Parameters:
- PC_W, 32, program counter width.
- DATA_W, 32, register data width; must be a multiple of 8.
- RADDR_W, 5, register address width.
- DEPTH, 2, buffer entries; legal values 1..4.
- CNT_W, 32, performance counter width (used only with WB_PERF_CNT_EN).
- Derived localparams: BE_W = DATA_W/8; BUS_WD = PC_W+BE_W+RADDR_W+DATA_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ms_to_ws_valid  in  1  memory stage has an entry.
- ms_to_ws_bus  in  BUS_WD  entry {pc, be, raddr, wdata}, MSB first.
- ws_allowin  out  1  stage can accept an entry this cycle.
- ws_flush  in  1  discard all buffered entries.
- rf_ready  in  1  register-file write port accepts this cycle.
- ws_to_rf_bus  out  BE_W+RADDR_W+DATA_W  {we, waddr, wdata}.
- ws_busy  out  1  buffer non-empty.
- ws_fwd_raddr  in  RADDR_W  bypass query address.
- ws_fwd_hit  out  1  a buffered entry writes ws_fwd_raddr.
- ws_fwd_be  out  BE_W  byte enables of the matching entry.
- ws_fwd_data  out  DATA_W  data of the matching entry.
- debug_wb_pc  out  PC_W  PC of the retiring entry.
- debug_wb_rf_we  out  BE_W  byte enables written this cycle.
- debug_wb_rf_waddr  out  RADDR_W  address written.
- debug_wb_rf_wdata  out  DATA_W  data written.
- perf_retired  out  CNT_W  retired entry count.
- perf_stall  out  CNT_W  stall cycle count.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port named reset.
- Storage:
  - Circular buffer with head pointer, tail pointer and count (0..DEPTH).
  - Pointers wrap modulo DEPTH; non-power-of-2 DEPTH (3) wraps explicitly.
- Reset: count=0, pointers=0, debug_wb_pc=0, all other outputs 0, ws_allowin=1.
- Push and pop:
  - pop = (count!=0) && rf_ready && !ws_flush.
  - ws_allowin = (count<DEPTH) || pop. This is combinational from count and rf_ready.
  - push = ms_to_ws_valid && ws_allowin && !ws_flush; the entry is written at tail.
  - Simultaneous push and pop when full is legal; count stays DEPTH.
  - Push into an empty buffer becomes visible at the head the next cycle. Minimum latency is 1 cycle from the accepting edge to the register-file write.
- Register-file write (combinational from head):
  - we = pop ? head.be : 0, except we is forced to 0 when head.raddr==0.
  - An r0 entry still pops and is still counted as retired.
  - waddr and wdata are the head fields whenever count!=0; 0 otherwise.
- Debug outputs:
  - debug_wb_rf_we/waddr/wdata mirror ws_to_rf_bus.
  - debug_wb_pc = head.pc when pop; otherwise it holds the last retired PC (registered).
- Flush:
  - ws_flush=1 sets count=0 and head=tail=0 at the edge.
  - No pop and no push occur in that cycle; we=0.
  - Flush while empty has no effect.
  - Flush asserted together with reset: reset dominates.
- Bypass:
  - Search all valid entries for raddr==ws_fwd_raddr and be!=0; ws_fwd_raddr==0 never hits.
  - When several entries match, the youngest (closest to tail) wins.
  - ws_fwd_be and ws_fwd_data come from the winning entry; both are 0 on a miss.
  - The search is purely combinational and includes the head entry even in its pop cycle.
- ws_busy = (count!=0).
- rf_ready low with count==DEPTH: ws_allowin=0 and the memory stage holds its entry. No entry is lost or duplicated.

Optional Feature:
WB_PERF_CNT_EN.
- Defined:
  - perf_retired increments on each pop.
  - perf_stall increments on each cycle with count!=0 && !rf_ready && !ws_flush.
  - Both counters wrap at 2^CNT_W and are cleared by reset only.
- Undefined: the counter logic is omitted and both outputs are tied to 0.

Test Plan:
- Basic retire: DEPTH=2; push {pc=0xBFC00000, be=4'hF, raddr=3, wdata=0x12345678} with rf_ready=1 -> next cycle ws_to_rf_bus we=F, waddr=3, wdata=0x12345678; debug_wb_pc=0xBFC00000; buffer then empty.
- Backpressure: rf_ready=0; push entries A (raddr=1) and B (raddr=2) -> ws_allowin=0 after 2 pushes; perf_stall counts up. Set rf_ready=1 -> A retires, then B, in order; simultaneous push of C at full is accepted and retires third.
- r0 suppression: push raddr=0, be=F -> we=0 on the pop cycle; perf_retired increments by 1.
- Bypass priority: buffer holds raddr=5 data=0x11 (older) and raddr=5 data=0x22 with be=4'h3 (younger); ws_fwd_raddr=5 -> hit=1, data=0x22, be=3. Query raddr=0 -> hit=0.
- Flush: buffer full, assert ws_flush with ms_to_ws_valid=1 -> next cycle count=0, no write occurred in the flush cycle, the incoming entry is dropped, ws_busy=0.
- Async reset mid-operation: assert reset between edges with 2 entries buffered -> outputs go to 0 immediately and ws_allowin=1; after deassert, a first push retires normally.
